div_result_display: RTL



---
 rtl/div_result_display_pkg.sv | 42 ++++
 rtl/div_result_display_seg7_decoder.sv | 30 +++
 rtl/div_result_display.sv | 120 ++++++++++++
 3 files changed

// File: rtl/div_result_display_pkg.sv
// Shared constants and helpers for the divider result display.
// Segment codes are active-high, ordered {g,f,e,d,c,b,a}.
package div_result_display_pkg;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic [1:0] {
    DIG_R_UNITS = 2'd0,
    DIG_R_TENS  = 2'd1,
    DIG_Q_UNITS = 2'd2,
    DIG_Q_TENS  = 2'd3
  } digit_e;

  typedef struct packed {
    logic       tens;
    logic [3:0] units;
  } bcd2_t;

  // A 4-bit value never exceeds 15, so the tens digit is at most 1.
  function automatic bcd2_t split_dec(input logic [3:0] v);
    bcd2_t d;
    if (v >= 4'd10) begin
      d.tens  = 1'b1;
      d.units = v - 4'd10;
    end else begin
      d.tens  = 1'b0;
      d.units = v;
    end
    return d;
  endfunction

endpackage

// File: rtl/div_result_display_seg7_decoder.sv
// Combinational BCD digit to active-high 7-segment pattern.
// Out-of-range digits and the blank flag both produce an unlit digit.
module seg7_decoder
  import div_result_display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/div_result_display.sv
// Captures divider quotient/remainder on done rising and scans them as
// two 2-digit decimal numbers onto a multiplexed 4-digit 7-segment display.
module div_result_display
  import div_result_display_pkg::*;
#(
  parameter int REFRESH_DIV    = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] result,
  input  logic [3:0] rest,
  input  logic       done,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp,
  output logic       shown
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7f : 7'h00;
  localparam logic [3:0] AN_OFF  = SEG_ACTIVE_LOW ? 4'hf  : 4'h0;
  localparam logic       DP_OFF  = SEG_ACTIVE_LOW;

  logic             done_q;
  logic [3:0]       q_reg;
  logic [3:0]       r_reg;
  logic [CNT_W-1:0] scan_cnt;
  digit_e           digit_idx;

  bcd2_t      q_dec;
  bcd2_t      r_dec;
  logic [3:0] cur_digit;
  logic       cur_blank;
  logic [6:0] seg_hi;
  logic [3:0] an_hi;
  logic       dp_hi;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q <= 1'b0;
      q_reg  <= '0;
      r_reg  <= '0;
      shown  <= 1'b0;
    end else begin
      done_q <= done;
      if (done && !done_q) begin
        q_reg <= result;
        r_reg <= rest;
        shown <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt  <= '0;
      digit_idx <= DIG_R_UNITS;
    end else if (scan_cnt == CNT_LAST) begin
      scan_cnt  <= '0;
      digit_idx <= digit_e'(digit_idx + 2'd1);
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  always_comb begin
    q_dec     = split_dec(q_reg);
    r_dec     = split_dec(r_reg);
    cur_digit = '0;
    cur_blank = 1'b1;
    case (digit_idx)
      DIG_R_UNITS: begin
        cur_digit = r_dec.units;
        cur_blank = 1'b0;
      end
      DIG_R_TENS: begin
        cur_digit = {3'b000, r_dec.tens};
        cur_blank = !r_dec.tens;
      end
      DIG_Q_UNITS: begin
        cur_digit = q_dec.units;
        cur_blank = 1'b0;
      end
      DIG_Q_TENS: begin
        cur_digit = {3'b000, q_dec.tens};
        cur_blank = !q_dec.tens;
      end
      default: begin
        cur_digit = '0;
        cur_blank = 1'b1;
      end
    endcase
    if (!shown) cur_blank = 1'b1;
    an_hi = 4'b0001 << digit_idx;
    dp_hi = shown && (digit_idx == DIG_Q_UNITS);
  end

  seg7_decoder u_dec (
    .digit (cur_digit),
    .blank (cur_blank),
    .seg   (seg_hi)
  );

  // Anodes, segments and dp share one register stage so they never skew.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg <= SEG_OFF;
      an  <= AN_OFF;
      dp  <= DP_OFF;
    end else begin
      seg <= SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
      an  <= SEG_ACTIVE_LOW ? ~an_hi  : an_hi;
      dp  <= SEG_ACTIVE_LOW ? ~dp_hi  : dp_hi;
    end
  end

endmodule
